// File: rtl/dram_dma.sv
// Block-transfer initiator on the data-RAM port: word copy (src->dst) or constant fill.
// Copy takes 2 cycles/word, fill 1 cycle/word, plus one DONE cycle; no input-to-output paths.
module dram_dma #(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          mode,
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] dst,
  input  logic [AW-1:0] len,
  input  logic [DW-1:0] fill_val,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] remaining,
  output logic          mem_read,
  output logic          mem_write,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t        state_q;
  logic [AW-1:0] src_q, dst_q, rem_q;
  logic [DW-1:0] buf_q, fv_q;
  logic          md_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      buf_q   <= '0;
      fv_q    <= '0;
      md_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            src_q <= src;
            dst_q <= dst;
            rem_q <= len;
            fv_q  <= fill_val;
            md_q  <= mode;
            if (len == '0)  state_q <= DONE;
            else if (mode)  state_q <= WR;
            else            state_q <= RD;
          end
        end
        RD: begin
          buf_q   <= mem_rdata;
          src_q   <= src_q + 1'b1;
          state_q <= abort ? IDLE : WR;
        end
        WR: begin
          // The write in an abort cycle still commits, so pointers always advance.
          dst_q <= dst_q + 1'b1;
          rem_q <= rem_q - 1'b1;
          if (abort)                        state_q <= IDLE;
          else if (rem_q == {{(AW-1){1'b0}}, 1'b1}) state_q <= DONE;
          else if (md_q)                    state_q <= WR;
          else                              state_q <= RD;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
    remaining = rem_q;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      RD: begin
        mem_read = 1'b1;
        mem_addr = src_q;
      end
      WR: begin
        mem_write = 1'b1;
        mem_addr  = dst_q;
        mem_wdata = md_q ? fv_q : buf_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dram_dma.sv
// Bench for dram_dma: RAM model, strobe monitor, and a word-level reference of copy/fill.
`timescale 1ns/1ps
module tb_dram_dma;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        start = 1'b0, mode = 1'b0, abort = 1'b0;
  logic [15:0] src = '0, dst = '0, len = '0, fill_val = '0;
  logic        busy, done, mem_read, mem_write;
  logic [15:0] remaining, mem_addr, mem_wdata, mem_rdata;

  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  dram_dma #(.AW(16), .DW(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .src(src), .dst(dst),
    .len(len), .fill_val(fill_val), .abort(abort), .busy(busy), .done(done),
    .remaining(remaining), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // RAM model: combinational read, write commits at posedge; pokes only while the DUT is idle.
  logic [15:0] ram [0:65535];
  logic [15:0] model_mem [0:65535];
  logic        poke_en = 1'b0;
  logic [15:0] poke_a = '0, poke_d = '0;

  function automatic logic [15:0] init_val(int i);
    return 16'(i * 40503) ^ 16'h5a5a;
  endfunction

  assign mem_rdata = mem_read ? ram[mem_addr] : 16'h0;

  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = init_val(i);
    forever begin
      @(posedge clk);
      if (mem_write) ram[mem_addr] = mem_wdata;
      else if (poke_en) ram[poke_a] = poke_d;
    end
  end

  // Monitor sampled on the falling edge.
  int          busy_cnt = 0, done_cnt = 0, done_at = 0, both_cnt = 0;
  logic        trace[$];
  logic [15:0] wl_a[$], wl_d[$];

  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (done) begin done_cnt++; done_at = busy_cnt; end
    if (mem_read && mem_write) both_cnt++;
    if (mem_read) trace.push_back(1'b0);
    if (mem_write) begin
      trace.push_back(1'b1);
      wl_a.push_back(mem_addr);
      wl_d.push_back(mem_wdata);
    end
  end

  int b0, d0, t0, w0, b1, c0;
  logic [15:0] ea[$], ed[$];

  task automatic mark();
    b0 = busy_cnt; d0 = done_cnt; t0 = trace.size(); w0 = wl_a.size(); c0 = both_cnt;
  endtask

  task automatic poke(input logic [15:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    poke_en = 1'b1; poke_a = a; poke_d = d; model_mem[a] = d;
    @(posedge clk); #1;
    poke_en = 1'b0;
  endtask

  task automatic go(input logic m, input logic [15:0] s, input logic [15:0] d,
                    input logic [15:0] l, input logic [15:0] f);
    @(posedge clk); #1;
    mark();
    start = 1'b1; mode = m; src = s; dst = d; len = l; fill_val = f;
    @(posedge clk); #1;
    start = 1'b0;
    mode = 1'($urandom); src = 16'($urandom); dst = 16'($urandom);
    len = 16'($urandom); fill_val = 16'($urandom);
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
  endtask

  // Reference: word i is read from src+i (after any earlier writes) and written to dst+i.
  task automatic model(input logic m, input logic [15:0] s, input logic [15:0] d,
                       input int n, input logic [15:0] f, input int nw);
    logic [15:0] a, v;
    ea.delete(); ed.delete();
    for (int i = 0; i < n && i < nw; i++) begin
      a = d + 16'(i);
      v = m ? f : model_mem[16'(s + 16'(i))];
      model_mem[a] = v;
      ea.push_back(a); ed.push_back(v);
    end
  endtask

  function automatic int log_diff();
    int n = wl_a.size() - w0;
    int bad = (n != ea.size()) ? 1 : 0;
    for (int i = 0; i < n && i < ea.size(); i++)
      if (wl_a[w0+i] !== ea[i] || wl_d[w0+i] !== ed[i]) bad++;
    return bad;
  endfunction

  function automatic int ram_diff();
    int bad = 0;
    foreach (ea[i]) if (ram[ea[i]] !== model_mem[ea[i]]) bad++;
    return bad;
  endfunction

  task automatic test_reset();
    #2;
    checks++;
    if ({busy, done, mem_read, mem_write} !== 4'b0) begin
      errors++; $display("FAIL reset_flags got %b exp 0000", {busy, done, mem_read, mem_write});
    end
    checks++;
    if ({remaining, mem_addr, mem_wdata} !== 48'h0) begin
      errors++; $display("FAIL reset_buses got %h exp 0", {remaining, mem_addr, mem_wdata});
    end
    #20 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle busy got %b exp 0", busy); end
  endtask

  task automatic test_copy();
    bit ok; int bad;
    poke(16'h0100, 16'h1111); poke(16'h0101, 16'h2222);
    poke(16'h0102, 16'h3333); poke(16'h0103, 16'h4444);
    go(1'b0, 16'h0100, 16'h0200, 16'd4, 16'($urandom));
    wait_idle(ok);
    model(1'b0, 16'h0100, 16'h0200, 4, 16'h0, 4);
    checks++; if (!ok) begin errors++; $display("FAIL copy_timeout got busy exp idle"); end
    checks++; if (busy_cnt - b0 != 9) begin errors++; $display("FAIL copy_busy got %0d exp 9", busy_cnt - b0); end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL copy_done got %0d exp 1", done_cnt - d0); end
    checks++; if (remaining !== 16'h0) begin errors++; $display("FAIL copy_rem got %0d exp 0", remaining); end
    bad = (trace.size() - t0 != 8) ? 1 : 0;
    for (int i = t0; i < trace.size(); i++) if (trace[i] !== 1'((i - t0) % 2)) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL copy_strobes got %0d bad exp 0", bad); end
    checks++; if (log_diff() != 0) begin errors++; $display("FAIL copy_log got %0d bad exp 0", log_diff()); end
    checks++; if (ram[16'h0203] !== 16'h4444) begin errors++; $display("FAIL copy_ram got %h exp 4444", ram[16'h0203]); end
    checks++; if (ram_diff() != 0) begin errors++; $display("FAIL copy_ramall got %0d bad exp 0", ram_diff()); end
  endtask

  task automatic test_fill();
    bit ok; int bad; logic [15:0] pre;
    pre = model_mem[16'h0013];
    go(1'b1, 16'($urandom), 16'h0010, 16'd3, 16'hBEEF);
    wait_idle(ok);
    model(1'b1, 16'h0, 16'h0010, 3, 16'hBEEF, 3);
    checks++; if (!ok) begin errors++; $display("FAIL fill_timeout got busy exp idle"); end
    bad = (trace.size() - t0 != 3) ? 1 : 0;
    for (int i = t0; i < trace.size(); i++) if (trace[i] !== 1'b1) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL fill_strobes got %0d bad exp 0", bad); end
    checks++; if (done_at - b0 != 4) begin errors++; $display("FAIL fill_done_at got %0d exp 4", done_at - b0); end
    checks++; if (log_diff() != 0) begin errors++; $display("FAIL fill_log got %0d bad exp 0", log_diff()); end
    checks++; if (ram[16'h0013] !== pre) begin errors++; $display("FAIL fill_untouched got %h exp %h", ram[16'h0013], pre); end
  endtask

  task automatic test_len0();
    bit ok;
    go(1'($urandom), 16'($urandom), 16'($urandom), 16'd0, 16'($urandom));
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL len0_timeout got busy exp idle"); end
    checks++; if (done_at - b0 != 1 || done_cnt - d0 != 1) begin
      errors++; $display("FAIL len0_done got at %0d cnt %0d exp at 1 cnt 1", done_at - b0, done_cnt - d0);
    end
    checks++; if (trace.size() - t0 != 0) begin errors++; $display("FAIL len0_strobes got %0d exp 0", trace.size() - t0); end
  endtask

  task automatic test_wrap();
    bit ok;
    go(1'b1, 16'h0, 16'hFFFE, 16'd4, 16'h00AA);
    wait_idle(ok);
    model(1'b1, 16'h0, 16'hFFFE, 4, 16'h00AA, 4);
    checks++; if (!ok) begin errors++; $display("FAIL wrap_timeout got busy exp idle"); end
    checks++; if (log_diff() != 0) begin errors++; $display("FAIL wrap_log got %0d bad exp 0", log_diff()); end
    checks++; if (wl_a[wl_a.size()-2] !== 16'h0000) begin errors++; $display("FAIL wrap_addr got %h exp 0000", wl_a[wl_a.size()-2]); end
  endtask

  task automatic test_abort();
    int wc = 0; bit hit = 1'b0;
    go(1'b0, 16'h0300, 16'h0400, 16'd8, 16'h0);
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (mem_write) begin
        wc++;
        if (wc == 1) begin start = 1'b1; mode = 1'b1; dst = 16'h0500; len = 16'd2; end
        if (wc == 3) begin abort = 1'b1; hit = 1'b1; end
      end
    end
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    model(1'b0, 16'h0300, 16'h0400, 8, 16'h0, 3);
    checks++; if (!hit) begin errors++; $display("FAIL abort_timeout got %0d writes exp 3", wc); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_idle busy got %b exp 0", busy); end
    checks++; if (remaining !== 16'd5) begin errors++; $display("FAIL abort_rem got %0d exp 5", remaining); end
    repeat (3) @(negedge clk);
    checks++; if (done_cnt - d0 != 0) begin errors++; $display("FAIL abort_done got %0d exp 0", done_cnt - d0); end
    checks++; if (log_diff() != 0) begin errors++; $display("FAIL abort_log got %0d bad exp 0", log_diff()); end
  endtask

  task automatic test_reset_mid();
    bit ok; int wc = 0; logic [15:0] fv, pre;
    fv = 16'($urandom); pre = model_mem[16'h0604];
    go(1'b1, 16'h0, 16'h0600, 16'd10, fv);
    for (int i = 0; i < 100 && wc < 4; i++) begin
      @(negedge clk);
      if (mem_write) wc++;
    end
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    model(1'b1, 16'h0, 16'h0600, 10, fv, 4);
    checks++;
    if ({busy, done, mem_read, mem_write, remaining, mem_addr, mem_wdata} !== 52'h0) begin
      errors++; $display("FAIL rstmid_outputs got %b%b%b%b %h %h %h exp 0", busy, done, mem_read,
                         mem_write, remaining, mem_addr, mem_wdata);
    end
    #2 rst_n = 1'b1;
    checks++; if (log_diff() != 0 || ram_diff() != 0) begin
      errors++; $display("FAIL rstmid_written got log %0d ram %0d exp 0 0", log_diff(), ram_diff());
    end
    checks++; if (ram[16'h0604] !== pre) begin errors++; $display("FAIL rstmid_untouched got %h exp %h", ram[16'h0604], pre); end
    fv = 16'($urandom);
    go(1'b1, 16'h0, 16'h0700, 16'd2, fv);
    wait_idle(ok);
    model(1'b1, 16'h0, 16'h0700, 2, fv, 2);
    checks++; if (!ok || done_cnt - d0 != 1) begin
      errors++; $display("FAIL rstmid_restart got ok %0d done %0d exp 1 1", ok, done_cnt - d0);
    end
    checks++; if (log_diff() != 0) begin errors++; $display("FAIL rstmid_log got %0d bad exp 0", log_diff()); end
  endtask

  task automatic test_random();
    bit ok; logic m; logic [15:0] s, d, f; int n, exp_busy;
    for (int it = 0; it < 10; it++) begin
      m = 1'($urandom); n = $urandom_range(1, 12); s = 16'($urandom); f = 16'($urandom);
      d = ($urandom_range(0, 2) == 0) ? s + 16'($urandom_range(0, 3)) : 16'($urandom);
      go(m, s, d, 16'(n), f);
      wait_idle(ok);
      model(m, s, d, n, f, n);
      exp_busy = (m ? n : 2 * n) + 1;
      checks++; if (!ok) begin errors++; $display("FAIL rand%0d_timeout got busy exp idle", it); end
      checks++; if (busy_cnt - b0 != exp_busy || done_cnt - d0 != 1) begin
        errors++; $display("FAIL rand%0d_timing got busy %0d done %0d exp %0d 1", it, busy_cnt - b0, done_cnt - d0, exp_busy);
      end
      checks++; if (log_diff() != 0 || ram_diff() != 0) begin
        errors++; $display("FAIL rand%0d_data got log %0d ram %0d exp 0 0", it, log_diff(), ram_diff());
      end
      checks++; if (remaining !== 16'h0 || both_cnt != c0) begin
        errors++; $display("FAIL rand%0d_misc got rem %0d both %0d exp 0 0", it, remaining, both_cnt - c0);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) model_mem[i] = init_val(i);
    test_reset();
    test_copy();
    test_fill();
    test_len0();
    test_wrap();
    test_abort();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
